serial_subtractor_ctrl: RTL and testbench
=========================================

Name: serial_subtractor_ctrl

Overview:
- Bit-serial WIDTH-bit subtractor controller that sequences a single 1-bit subtract cell (difference/borrow) over WIDTH clock cycles, LSB first.
- Replaces a WIDTH-wide ripple subtractor where area matters.
- Sits between a requester, which issues operands with a start/done handshake, and downstream logic that consumes diff and bout.

Parameters:
- WIDTH, 8, operand and result width in bits (must be ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only while idle
- a  input  WIDTH  minuend, captured on accepted start
- b  input  WIDTH  subtrahend, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until done is asserted
- done  output  1  one-cycle pulse: result valid
- diff  output  WIDTH  a − b modulo 2^WIDTH, registered
- bout  output  1  final borrow; 1 when a < b (unsigned)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
  - rst high at a rising edge forces state=IDLE, busy=0, done=0, diff=0, bout=0, and clears internal shift registers, borrow and bit counter.
  - rst has priority over every other input, including mid-operation; the aborted operation produces no done.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - start=1 at an edge loads a into shift register A and b into shift register B, clears borrow register br and counter cnt, and moves to SHIFT.
  - a and b are don't-care outside the capture edge.
- SHIFT:
  - busy=1.
  - Each edge computes d = A[0]^B[0]^br and br_next = (~A[0]&B[0]) | (~(A[0]^B[0])&br).
  - Shifts A and B right by 1.
  - Shifts d into the MSB of result register R, shifting R right.
  - Increments cnt.
  - On the edge where cnt == WIDTH−1: loads diff from the final R value (including this bit), loads bout from br_next, and moves to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start in DONE is ignored.
- Latency and throughput:
  - The accepted-start edge is edge 0; done is high in the cycle following edge WIDTH.
  - Back-to-back operation: start may be asserted in the cycle done is high, but it is ignored. The next start is accepted in IDLE, giving a throughput of one operation per WIDTH+2 cycles.
- start while busy (SHIFT) or in DONE: ignored, no queuing; operands are not re-captured.
- diff and bout hold their last values until the next completion or reset. They never show partial results.
- Arithmetic:
  - diff = (a − b) mod 2^WIDTH.
  - bout = (a < b).
  - Operands are unsigned. Two's-complement signed interpretation of diff is valid when no overflow occurs; overflow is not flagged.
- cnt width: $clog2(WIDTH). No wrap inside an operation; cnt is cleared at capture.

Optional Feature:
- Macro SERIAL_SUB_ZERO_FLAG_EN.
- When defined:
  - Adds output port zero (1 bit, registered).
  - zero is loaded together with diff at completion: zero=1 iff the final diff == 0.
  - Reset value 0.
  - Tracked serially as the OR of all d bits during SHIFT. No WIDTH-wide compare is allowed.
- When undefined: port zero does not exist; all other behaviour is identical.

Test Plan:
- Reset, then a=0x5A, b=0x23, start pulse → busy high for 8 cycles, done pulse in cycle after edge 8; diff=0x37, bout=0 (zero=0 if enabled).
- a=0x10, b=0x20 → diff=0xF0, bout=1. Then a=0xFF, b=0x01 → diff=0xFE, bout=0; diff holds 0xF0 until the second done.
- a=0x00, b=0x00 → diff=0x00, bout=0, zero=1 with SERIAL_SUB_ZERO_FLAG_EN. Then a=0x00, b=0x01 → diff=0xFF, bout=1, zero=0.
- Start with a=0x5A, b=0x23; on edge 3 assert start again with a=0x01, b=0x01 → ignored; result still diff=0x37 at done. Start held high through DONE → next operation begins only from IDLE.
- Start a=0x80, b=0x01; assert rst at edge 4 for one cycle → busy=0, done never pulses, diff=0, bout=0. Then a fresh start a=0x80, b=0x01 → diff=0x7F, bout=0.
- WIDTH=2 build: a=2'b01, b=2'b10 → diff=2'b11, bout=1, done after edge 2.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one subtract cell, LSB first, start/done handshake.
// Optional zero flag output when SERIAL_SUB_ZERO_FLAG_EN is defined.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // R keeps only the bits still in flight; the newest bit completes it.
    logic [WIDTH-2:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             nz_q, nz_d;
    logic             zero_q, zero_d;
`endif

    logic             bit_d;
    logic             br_nx;
    logic [WIDTH-1:0] r_full;
    logic             last;

    // One subtract cell and the assembled result word.
    always_comb begin
        bit_d  = a_q[0] ^ b_q[0] ^ br_q;
        br_nx  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        r_full = {bit_d, r_q};
        last   = (cnt_q == LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture, shift, and result load.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        r_d    = r_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        nz_d   = nz_q;
        zero_d = zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    r_d   = '0;
                    br_d  = 1'b0;
                    cnt_d = '0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                    nz_d  = 1'b0;
`endif
                end
            end
            SHIFT: begin
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                r_d  = r_full[WIDTH-1:1];
                br_d = br_nx;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                nz_d = nz_q | bit_d;
`endif
                if (last) begin
                    diff_d = r_full;
                    bout_d = br_nx;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                    zero_d = ~(nz_q | bit_d);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            nz_q   <= 1'b0;
            zero_q <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            r_q    <= r_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            nz_q   <= nz_d;
            zero_q <= zero_d;
`endif
        end
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        zero = zero_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: directed table, corner sequences, random ops.
// Also exercises a WIDTH=2 instance.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i, b_i;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic         zero;
`endif

    logic         start2;
    logic [1:0]   a2, b2;
    logic         busy2, done2, bout2;
    logic [1:0]   diff2;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic         zero2;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_diff;
    logic         m_bout;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        , .zero(zero2)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_result(input string nm, input logic [W-1:0] ed,
                              input logic ebo);
        chk({nm, "_diff"}, int'(diff), int'(ed));
        chk({nm, "_bout"}, int'(bout), int'(ebo));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk({nm, "_zero"}, int'(zero), int'(ed == '0));
`endif
    endtask

    // One operation; glitch>0 re-asserts start on that edge, hold keeps start high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic ebo,
                          input int glitch, input bit hold, input string nm);
        int n;
        int bc;
        bit held;
        @(negedge clk);
        a_i = a; b_i = b; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n = 0; bc = 0; held = 1'b1;
        while (!done && n < 4 * W) begin
            if (busy) bc++;
            if (diff != m_diff || bout != m_bout) held = 1'b0;
            if (glitch > 0 && n == glitch - 1) begin
                start = 1'b1; a_i = 8'h01; b_i = 8'h01;
            end else if (!hold) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, n, W);
        chk({nm, "_busycyc"}, bc, W);
        chk({nm, "_busy_at_done"}, int'(busy), 0);
        chk({nm, "_held"}, int'(held), 1);
        chk_result(nm, ed, ebo);
        m_diff = ed; m_bout = ebo;
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, int'(done), 0);
        chk({nm, "_idle"}, int'(busy), 0);
        if (hold) begin
            @(posedge clk); #1;
            chk({nm, "_restart"}, int'(busy), 1);
            start = 1'b0;
            n = 0;
            while (!done && n < 4 * W) begin
                @(posedge clk); #1;
                n++;
            end
            chk({nm, "_lat2"}, n, W);
            chk_result({nm, "2"}, ed, ebo);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        bit seen;
        logic [W-1:0] ra, rb;

        vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1};

        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        m_diff = '0; m_bout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk_result("rst", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, 0, 1'b0,
                   $sformatf("vec%0d", i));

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 3, 1'b0, "glitch");
        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 0, 1'b1, "hold");

        // Abort with reset on edge 4.
        @(negedge clk);
        a_i = 8'h80; b_i = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        m_diff = '0; m_bout = 1'b0;
        chk_result("abort", 8'h00, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_nodone", int'(seen), 0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 0, 1'b0, "after_abort");

        // WIDTH=2 instance.
        @(negedge clk);
        a2 = 2'b01; b2 = 2'b10; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w2_lat", n, 2);
        chk("w2_diff", int'(diff2), 3);
        chk("w2_bout", int'(bout2), 1);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk("w2_zero", int'(zero2), 0);
`endif

        // Random operations against plain arithmetic.
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = (i % 7 == 0) ? ra : W'($urandom);
            run_op(ra, rb, ra - rb, ra < rb, 0, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
